// File: rtl/rv32_fxmadd_seq_if.sv
// Handshake and datapath bundle between issue logic, the fxmadd sequencer and the fxmadd unit.
// FXMADD_SEQ_ABORT_EN adds the abort request line.
interface rv32_fxmadd_seq_if #(
  parameter int unsigned MAX_LEN_W = 8
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [MAX_LEN_W-1:0] cmd_len;
  logic [2:0]           cmd_scale;
  logic [31:0]          cmd_init;

  logic                 op_valid;
  logic                 op_ready;
  logic [31:0]          op_a;
  logic [31:0]          op_b;

  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [2:0]           cfg_slot;
  logic [4:0]           cfg_scale;

  logic [31:0]          fx_mul_op_1;
  logic [31:0]          fx_mul_op_2;
  logic [31:0]          fx_add_op;
  logic [2:0]           fx_selected_scale;
  logic                 fx_write_enable;
  logic [4:0]           fx_new_scale;
  logic [31:0]          fx_result;

  logic                 res_valid;
  logic                 res_ready;
  logic [31:0]          res_data;

  logic                 busy;
`ifdef FXMADD_SEQ_ABORT_EN
  logic                 abort;
`endif

  // Issue side together with the fxmadd unit model.
  modport master (
    output cmd_valid, cmd_len, cmd_scale, cmd_init,
    output op_valid, op_a, op_b,
    output cfg_valid, cfg_slot, cfg_scale,
    output res_ready, fx_result,
`ifdef FXMADD_SEQ_ABORT_EN
    output abort,
`endif
    input  cmd_ready, op_ready, cfg_ready,
    input  fx_mul_op_1, fx_mul_op_2, fx_add_op,
    input  fx_selected_scale, fx_write_enable, fx_new_scale,
    input  res_valid, res_data, busy
  );

  modport slave (
    input  cmd_valid, cmd_len, cmd_scale, cmd_init,
    input  op_valid, op_a, op_b,
    input  cfg_valid, cfg_slot, cfg_scale,
    input  res_ready, fx_result,
`ifdef FXMADD_SEQ_ABORT_EN
    input  abort,
`endif
    output cmd_ready, op_ready, cfg_ready,
    output fx_mul_op_1, fx_mul_op_2, fx_add_op,
    output fx_selected_scale, fx_write_enable, fx_new_scale,
    output res_valid, res_data, busy
  );
endinterface

// File: rtl/rv32_fxmadd_seq.sv
// Dot-product sequencer and scale-table write arbiter for the fixed-point multiply-add unit.
// Optional FXMADD_SEQ_ABORT_EN adds an abort input that cancels a running or finished command.
module rv32_fxmadd_seq #(
  parameter int unsigned MAX_LEN_W = 8
) (
  input logic              clk,
  input logic              rstn,
  rv32_fxmadd_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t               state, state_nxt;
  logic [31:0]          acc, acc_nxt;
  logic [MAX_LEN_W-1:0] cnt, cnt_nxt;
  logic [2:0]           scale, scale_nxt;
  logic                 abort_req;

  logic                 cmd_ready_c, op_ready_c, cfg_ready_c, res_valid_c;
  logic [31:0]          mul_op_1_c, mul_op_2_c, add_op_c;
  logic [2:0]           sel_scale_c;
  logic                 we_c;
  logic [4:0]           new_scale_c;

`ifdef FXMADD_SEQ_ABORT_EN
  assign abort_req = bus.abort;
`else
  assign abort_req = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      scale <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      scale <= scale_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    acc_nxt     = acc;
    cnt_nxt     = cnt;
    scale_nxt   = scale;
    cmd_ready_c = 1'b0;
    op_ready_c  = 1'b0;
    cfg_ready_c = 1'b0;
    res_valid_c = 1'b0;
    mul_op_1_c  = '0;
    mul_op_2_c  = '0;
    add_op_c    = '0;
    sel_scale_c = '0;
    we_c        = 1'b0;
    new_scale_c = '0;

    unique case (state)
      IDLE: begin
        cfg_ready_c = 1'b1;
        // A pending config write blocks the command for this cycle, so the
        // command always sees the freshly written scale on the next one.
        cmd_ready_c = !bus.cfg_valid;
        if (bus.cfg_valid) begin
          we_c        = 1'b1;
          sel_scale_c = bus.cfg_slot;
          new_scale_c = bus.cfg_scale;
        end else if (bus.cmd_valid) begin
          acc_nxt   = bus.cmd_init;
          cnt_nxt   = bus.cmd_len;
          scale_nxt = bus.cmd_scale;
          state_nxt = (bus.cmd_len == '0) ? DONE : RUN;
        end
      end

      RUN: begin
        // Abort wins over an operand handshake by withholding op_ready.
        op_ready_c  = !abort_req;
        mul_op_1_c  = bus.op_a;
        mul_op_2_c  = bus.op_b;
        add_op_c    = acc;
        sel_scale_c = scale;
        if (abort_req) begin
          state_nxt = IDLE;
        end else if (bus.op_valid) begin
          acc_nxt = bus.fx_result;
          cnt_nxt = cnt - MAX_LEN_W'(1);
          if (cnt == MAX_LEN_W'(1)) begin
            state_nxt = DONE;
          end
        end
      end

      DONE: begin
        res_valid_c = !abort_req;
        if (abort_req || bus.res_ready) begin
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign bus.cmd_ready         = cmd_ready_c;
  assign bus.op_ready          = op_ready_c;
  assign bus.cfg_ready         = cfg_ready_c;
  assign bus.res_valid         = res_valid_c;
  assign bus.res_data          = acc;
  assign bus.busy              = (state != IDLE);
  assign bus.fx_mul_op_1       = mul_op_1_c;
  assign bus.fx_mul_op_2       = mul_op_2_c;
  assign bus.fx_add_op         = add_op_c;
  assign bus.fx_selected_scale = sel_scale_c;
  assign bus.fx_write_enable   = we_c;
  assign bus.fx_new_scale      = new_scale_c;

endmodule

// File: tb/tb_rv32_fxmadd_seq.sv
// Directed bench for rv32_fxmadd_seq with a behavioural fxmadd unit (scale table reset to slot i -> shift i).
module tb_rv32_fxmadd_seq;

  logic clk;
  logic rstn;
  int   ncmp;
  int   nfail;
  logic [4:0] tbl [8];

  rv32_fxmadd_seq_if #(.MAX_LEN_W(8)) bus ();

  rv32_fxmadd_seq #(.MAX_LEN_W(8)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] fx_model(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] add, input logic [4:0] sh);
    logic signed [63:0] p;
    p = $signed(a) * $signed(b);
    p = p >>> sh;
    return p[31:0] + add;
  endfunction

  assign bus.fx_result = fx_model(bus.fx_mul_op_1, bus.fx_mul_op_2, bus.fx_add_op,
                                  tbl[bus.fx_selected_scale]);

  initial begin
    for (int i = 0; i < 8; i++) tbl[i] = 5'(i);
  end

  always @(posedge clk) begin
    if (bus.fx_write_enable) tbl[bus.fx_selected_scale] <= bus.fx_new_scale;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    ncmp  = 0;
    nfail = 0;
    rstn  = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_len = '0; bus.cmd_scale = '0; bus.cmd_init = '0;
    bus.op_valid  = 1'b0; bus.op_a = '0; bus.op_b = '0;
    bus.cfg_valid = 1'b0; bus.cfg_slot = '0; bus.cfg_scale = '0;
    bus.res_ready = 1'b0;
`ifdef FXMADD_SEQ_ABORT_EN
    bus.abort = 1'b0;
`endif
    repeat (2) step();
    settle();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_op_ready", 32'(bus.op_ready), 32'd0);
    chk("rst_we", 32'(bus.fx_write_enable), 32'd0);
    chk("rst_mul1", bus.fx_mul_op_1, 32'd0);
    chk("rst_add", bus.fx_add_op, 32'd0);
    rstn = 1'b1;

    // Three back-to-back pairs on default slot 2 (shift 2)
    step();
    bus.cmd_valid = 1'b1; bus.cmd_len = 8'd3; bus.cmd_init = 32'd0; bus.cmd_scale = 3'd2;
    settle();
    chk("t1_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    step();
    bus.cmd_valid = 1'b0;
    bus.op_valid = 1'b1; bus.op_a = 32'd8; bus.op_b = 32'd8;
    settle();
    chk("t1_busy", 32'(bus.busy), 32'd1);
    chk("t1_op_ready", 32'(bus.op_ready), 32'd1);
    chk("t1_sel", 32'(bus.fx_selected_scale), 32'd2);
    chk("t1_mul1", bus.fx_mul_op_1, 32'd8);
    step();
    bus.op_a = -32'sd4; bus.op_b = 32'd4;
    settle();
    chk("t1_add1", bus.fx_add_op, 32'd16);
    chk("t1_res_valid_early", 32'(bus.res_valid), 32'd0);
    step();
    bus.op_a = 32'd3; bus.op_b = 32'd4;
    settle();
    chk("t1_add2", bus.fx_add_op, 32'd12);
    step();
    bus.op_valid = 1'b0;
    settle();
    chk("t1_res_valid", 32'(bus.res_valid), 32'd1);
    chk("t1_res_data", bus.res_data, 32'd15);
    chk("t1_op_ready_done", 32'(bus.op_ready), 32'd0);
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    settle();
    chk("t1_idle_busy", 32'(bus.busy), 32'd0);

    // Config and command together: config wins, command next cycle
    bus.cfg_valid = 1'b1; bus.cfg_slot = 3'd2; bus.cfg_scale = 5'd0;
    bus.cmd_valid = 1'b1; bus.cmd_len = 8'd1; bus.cmd_init = 32'd5; bus.cmd_scale = 3'd2;
    settle();
    chk("t2_we", 32'(bus.fx_write_enable), 32'd1);
    chk("t2_sel", 32'(bus.fx_selected_scale), 32'd2);
    chk("t2_new", 32'(bus.fx_new_scale), 32'd0);
    chk("t2_cmd_ready_blk", 32'(bus.cmd_ready), 32'd0);
    step();
    bus.cfg_valid = 1'b0;
    settle();
    chk("t2_we_pulse", 32'(bus.fx_write_enable), 32'd0);
    chk("t2_not_busy", 32'(bus.busy), 32'd0);
    chk("t2_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    step();
    bus.cmd_valid = 1'b0;
    bus.op_valid = 1'b1; bus.op_a = 32'd3; bus.op_b = 32'd7;
    settle();
    chk("t2_add", bus.fx_add_op, 32'd5);
    step();
    bus.op_valid = 1'b0;
    settle();
    chk("t2_res_valid", 32'(bus.res_valid), 32'd1);
    chk("t2_res_data", bus.res_data, 32'd26);
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;

    // Zero-length command
    bus.cmd_valid = 1'b1; bus.cmd_len = 8'd0; bus.cmd_init = 32'h1234; bus.cmd_scale = 3'd0;
    step();
    bus.cmd_valid = 1'b0;
    settle();
    chk("t3_res_valid", 32'(bus.res_valid), 32'd1);
    chk("t3_res_data", bus.res_data, 32'h1234);
    chk("t3_op_ready", 32'(bus.op_ready), 32'd0);
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    settle();
    chk("t3_res_done", 32'(bus.res_valid), 32'd0);

    // Operand gaps and delayed result acceptance (slot 2 now shift 0)
    bus.cmd_valid = 1'b1; bus.cmd_len = 8'd2; bus.cmd_init = 32'd1; bus.cmd_scale = 3'd2;
    step();
    bus.cmd_valid = 1'b0;
    step();
    settle();
    chk("t4_gap_add", bus.fx_add_op, 32'd1);
    bus.op_valid = 1'b1; bus.op_a = 32'd2; bus.op_b = 32'd3;
    step();
    bus.op_valid = 1'b0;
    step();
    settle();
    chk("t4_gap_add2", bus.fx_add_op, 32'd7);
    chk("t4_gap_res_valid", 32'(bus.res_valid), 32'd0);
    bus.op_valid = 1'b1; bus.op_a = 32'd4; bus.op_b = 32'd5;
    step();
    bus.op_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("t4_hold_valid", 32'(bus.res_valid), 32'd1);
      chk("t4_hold_data", bus.res_data, 32'd27);
      step();
    end
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    settle();
    chk("t4_released", 32'(bus.res_valid), 32'd0);

    // Reset during RUN
    bus.cmd_valid = 1'b1; bus.cmd_len = 8'd4; bus.cmd_init = 32'd9; bus.cmd_scale = 3'd1;
    step();
    bus.cmd_valid = 1'b0;
    bus.op_valid = 1'b1; bus.op_a = 32'd1; bus.op_b = 32'd1;
    step();
    #2;
    rstn = 1'b0;
    settle();
    chk("t5_busy", 32'(bus.busy), 32'd0);
    chk("t5_op_ready", 32'(bus.op_ready), 32'd0);
    chk("t5_mul1", bus.fx_mul_op_1, 32'd0);
    chk("t5_add", bus.fx_add_op, 32'd0);
    chk("t5_res_valid", 32'(bus.res_valid), 32'd0);
    bus.op_valid = 1'b0;
    step();
    rstn = 1'b1;
    step();
    chk("t5_after_busy", 32'(bus.busy), 32'd0);

    // Scale table untouched by reset: slot 2 still shift 0
    bus.cmd_valid = 1'b1; bus.cmd_len = 8'd1; bus.cmd_init = 32'd0; bus.cmd_scale = 3'd2;
    step();
    bus.cmd_valid = 1'b0;
    bus.op_valid = 1'b1; bus.op_a = 32'd3; bus.op_b = 32'd7;
    step();
    bus.op_valid = 1'b0;
    settle();
    chk("t6_res_data", bus.res_data, 32'd21);
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;

`ifdef FXMADD_SEQ_ABORT_EN
    // Abort in RUN beats a same-cycle operand handshake
    bus.cmd_valid = 1'b1; bus.cmd_len = 8'd2; bus.cmd_init = 32'd0; bus.cmd_scale = 3'd2;
    step();
    bus.cmd_valid = 1'b0;
    bus.op_valid = 1'b1; bus.abort = 1'b1;
    settle();
    chk("ab_op_ready", 32'(bus.op_ready), 32'd0);
    step();
    bus.op_valid = 1'b0; bus.abort = 1'b0;
    settle();
    chk("ab_run_busy", 32'(bus.busy), 32'd0);
    chk("ab_run_res_valid", 32'(bus.res_valid), 32'd0);
    // Abort in DONE drops the result
    bus.cmd_valid = 1'b1; bus.cmd_len = 8'd0; bus.cmd_init = 32'd7;
    step();
    bus.cmd_valid = 1'b0;
    bus.abort = 1'b1; bus.res_ready = 1'b1;
    settle();
    chk("ab_done_res_valid", 32'(bus.res_valid), 32'd0);
    step();
    bus.abort = 1'b0; bus.res_ready = 1'b0;
    settle();
    chk("ab_done_busy", 32'(bus.busy), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
